// File: rtl/csa_pipe_adder_if.sv
// ============================================================================
// Module      : csa_pipe_adder_if
// Description : Operand/result handshake bundle for csa_pipe_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csa_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] i_add_term1;
    logic [WIDTH-1:0] i_add_term2;
    logic             i_cin;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer/consumer side
    modport master (
        output i_valid, i_add_term1, i_add_term2, i_cin, o_ready,
        input  i_ready, o_valid, sum, cout, ovf
    );

    // Adder side
    modport slave (
        input  i_valid, i_add_term1, i_add_term2, i_cin, o_ready,
        output i_ready, o_valid, sum, cout, ovf
    );
endinterface

`default_nettype wire

// File: rtl/csa_pipe_adder.sv
// ============================================================================
// Module      : csa_pipe_adder
// Description : Two-stage pipelined carry-select adder with valid/ready flow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLK_W = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    csa_pipe_adder_if.slave  bus
);

    localparam int NUM_BLK = WIDTH / BLK_W;

    if (((WIDTH % BLK_W) != 0) || (WIDTH < 2 * BLK_W)) begin : g_bad_param
        $error("csa_pipe_adder: WIDTH must be a multiple of BLK_W and >= 2*BLK_W");
    end

    logic                              w_en;
    logic [NUM_BLK-1:0][BLK_W-1:0]     w_sum0;
    logic [NUM_BLK-1:0]                w_c0;
    logic [NUM_BLK-1:1][BLK_W-1:0]     w_sum1;
    logic [NUM_BLK-1:1]                w_c1;

    logic [NUM_BLK-1:0][BLK_W-1:0]     r_sum0;
    logic [NUM_BLK-1:0]                r_c0;
    logic [NUM_BLK-1:1][BLK_W-1:0]     r_sum1;
    logic [NUM_BLK-1:1]                r_c1;
    logic                              r_a_msb;
    logic                              r_b_msb;
    logic                              r_v1;

    logic [NUM_BLK-1:0][BLK_W-1:0]     w_res;
    logic                              w_carry;
    logic                              w_ovf;

    logic [WIDTH-1:0]                  r_sum;
    logic                              r_cout;
    logic                              r_ovf;
    logic                              r_o_valid;

    assign w_en        = !r_o_valid || bus.o_ready;
    assign bus.i_ready = w_en;

    // Block 0 sees the real carry-in; upper blocks precompute both outcomes.
    for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
        logic [BLK_W-1:0] w_a;
        logic [BLK_W-1:0] w_b;
        assign w_a = bus.i_add_term1[k*BLK_W +: BLK_W];
        assign w_b = bus.i_add_term2[k*BLK_W +: BLK_W];
        if (k == 0) begin : g_lsb
            assign {w_c0[k], w_sum0[k]} = {1'b0, w_a} + {1'b0, w_b} + {{BLK_W{1'b0}}, bus.i_cin};
        end else begin : g_spec
            assign {w_c0[k], w_sum0[k]} = {1'b0, w_a} + {1'b0, w_b};
            assign {w_c1[k], w_sum1[k]} = {1'b0, w_a} + {1'b0, w_b} + {{BLK_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum0  <= '0;
            r_c0    <= '0;
            r_sum1  <= '0;
            r_c1    <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_v1    <= 1'b0;
        end else if (w_en) begin
            r_sum0  <= w_sum0;
            r_c0    <= w_c0;
            r_sum1  <= w_sum1;
            r_c1    <= w_c1;
            r_a_msb <= bus.i_add_term1[WIDTH-1];
            r_b_msb <= bus.i_add_term2[WIDTH-1];
            r_v1    <= bus.i_valid;
        end
    end

    // Select chain: each block's carry-out picks the next block's pair.
    always_comb begin
        w_res    = '0;
        w_carry  = r_c0[0];
        w_res[0] = r_sum0[0];
        for (int k = 1; k < NUM_BLK; k++) begin
            if (w_carry) begin
                w_res[k] = r_sum1[k];
                w_carry  = r_c1[k];
            end else begin
                w_res[k] = r_sum0[k];
                w_carry  = r_c0[k];
            end
        end
    end

    assign w_ovf = (r_a_msb == r_b_msb) && (w_res[NUM_BLK-1][BLK_W-1] != r_a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_o_valid <= 1'b0;
        end else if (w_en) begin
            r_sum     <= w_res;
            r_cout    <= w_carry;
            r_ovf     <= w_ovf;
            r_o_valid <= r_v1;
        end
    end

    assign bus.sum     = r_sum;
    assign bus.cout    = r_cout;
    assign bus.ovf     = r_ovf;
    assign bus.o_valid = r_o_valid;

endmodule

`default_nettype wire

// File: tb/tb_csa_pipe_adder.sv
// ============================================================================
// Module      : tb_csa_pipe_adder
// Description : Scoreboard bench for csa_pipe_adder (16/4, 9/3 and 32/8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_pipe_adder;

    typedef struct {
        logic [63:0] exp;
        int          stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_sw_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    bit   chk_lat = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa_pipe_adder_if #(.WIDTH(16)) bus ();

    csa_pipe_adder #(.WIDTH(16), .BLK_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference: plain integer sum plus signed-range test for overflow.
    function automatic logic [63:0] model(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin);
        logic [63:0] full;
        logic [63:0] lim;
        longint      sa, sb, ss;
        logic        ov;
        full = a + b + 64'(cin);
        lim  = 64'd1 << (w - 1);
        sa   = (a >= lim) ? longint'(a) - longint'(lim << 1) : longint'(a);
        sb   = (b >= lim) ? longint'(b) - longint'(lim << 1) : longint'(b);
        ss   = sa + sb + longint'(cin);
        ov   = (ss >= longint'(lim)) || (ss < -longint'(lim));
        return (full & ((lim << 1) - 64'd1)) | (64'(full[w]) << w) | (64'(ov) << (w + 1));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic ordy, output logic acc);
        bus.i_valid     = v;
        bus.i_add_term1 = a;
        bus.i_add_term2 = b;
        bus.i_cin       = cin;
        bus.o_ready     = ordy;
        @(negedge clk);
        acc = v && bus.i_ready;
        if (acc) q.push_back('{model(16, 64'(a), 64'(b), cin), cyc});
        @(posedge clk);
        #1;
    endtask

    // Default-config monitor: consume, or check the held result during a stall.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_result: got sum %0h, expected no result", bus.sum);
            end else if (bus.o_ready) begin
                exp_t it;
                it = q.pop_front();
                check("result16", 64'({bus.ovf, bus.cout, bus.sum}), it.exp);
                if (chk_lat) check("latency16", 64'(cyc), 64'(it.stamp + 2));
            end else begin
                check("stall_hold16", 64'({bus.ovf, bus.cout, bus.sum}), q[0].exp);
                check("stall_iready", 64'(bus.i_ready), 64'd0);
            end
        end
    end

    // Random-traffic sweep over the other two geometries.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 9 : 32;
        localparam int SB = (g == 0) ? 3 : 8;

        bit          done = 1'b0;
        logic [63:0] sq[$];

        csa_pipe_adder_if #(.WIDTH(SW)) sbus ();

        csa_pipe_adder #(.WIDTH(SW), .BLK_W(SB)) u_dut (
            .clk   (clk),
            .rst_n (rst_sw_n),
            .bus   (sbus.slave)
        );

        initial begin
            logic [SW-1:0] a, b;
            logic          cin;
            int            sent;
            sent             = 0;
            sbus.i_valid     = 1'b0;
            sbus.i_add_term1 = '0;
            sbus.i_add_term2 = '0;
            sbus.i_cin       = 1'b0;
            sbus.o_ready     = 1'b1;
            wait (rst_sw_n === 1'b1);
            @(posedge clk);
            #1;
            while (sent < 10000) begin
                a   = ($urandom_range(0, 7) == 0) ? '1 : SW'($urandom);
                b   = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
                cin = 1'($urandom);
                sbus.i_valid     = ($urandom_range(0, 3) != 0);
                sbus.i_add_term1 = a;
                sbus.i_add_term2 = b;
                sbus.i_cin       = cin;
                sbus.o_ready     = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (sbus.i_valid && sbus.i_ready) begin
                    sq.push_back(model(SW, 64'(a), 64'(b), cin));
                    sent++;
                end
                @(posedge clk);
                #1;
            end
            sbus.i_valid = 1'b0;
            sbus.o_ready = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("drain_w%0d", SW), 64'(sq.size()), 64'd0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (rst_sw_n && sbus.o_valid && sbus.o_ready) begin
                if (sq.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL spurious_w%0d: got sum %0h, expected no result", SW, sbus.sum);
                end else begin
                    check($sformatf("result_w%0d", SW), 64'({sbus.ovf, sbus.cout, sbus.sum}),
                          sq.pop_front());
                end
            end
        end
    end

    initial begin
        logic acc;
        int   idx;
        int   got;
        int   t;
        bus.i_valid     = 1'b0;
        bus.i_add_term1 = '0;
        bus.i_add_term2 = '0;
        bus.i_cin       = 1'b0;
        bus.o_ready     = 1'b1;
        rst_n           = 1'b0;
        rst_sw_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_valid", 64'(bus.o_valid), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout_ovf", 64'({bus.cout, bus.ovf}), 64'd0);
        check("rst_i_ready", 64'(bus.i_ready), 64'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        rst_sw_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry-propagation and overflow corners, back to back.
        chk_lat = 1'b1;
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, acc);
        step(1'b1, 16'h0FFF, 16'h0001, 1'b0, 1'b1, acc);
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, acc);
        step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, acc);
        repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);

        // Backpressure: four beats, o_ready low for cycles 2..7.
        chk_lat = 1'b0;
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            step(idx < 4, 16'(idx + 1), 16'(idx + 1), 1'b0, !(c >= 2 && c <= 7), acc);
            if (acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd4);
        check("bp_drained", 64'(q.size()), 64'd0);

        // Reset with two beats in flight.
        chk_lat = 1'b1;
        step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b1, acc);
        step(1'b1, 16'h0F0F, 16'h0101, 1'b1, 1'b1, acc);
        bus.i_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("midrst_o_valid", 64'(bus.o_valid), 64'd0);
        check("midrst_sum", 64'(bus.sum), 64'd0);
        check("midrst_cout_ovf", 64'({bus.cout, bus.ovf}), 64'd0);
        check("midrst_i_ready", 64'(bus.i_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
            check("post_rst_idle", 64'(bus.o_valid), 64'd0);
        end

        // 100 back-to-back random beats at full throughput.
        for (int i = 0; i < 100; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc);

        // Random valid/ready toggling.
        chk_lat = 1'b0;
        got = 0;
        for (int c = 0; c < 3000 && got < 300; c++) begin
            step(($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) != 0), acc);
            if (acc) got++;
        end
        check("rand_accepted", 64'(got), 64'd300);
        repeat (4) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        check("final_drain16", 64'(q.size()), 64'd0);

        t = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        check("sweep_finished", 64'(g_sweep[0].done && g_sweep[1].done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
